serializer_10b: RTL and testbench

Transmit-side partner of the 10-bit link deserializer. It pops pre-encoded 10-bit words from a TX FIFO and shifts them out one bit per clk, LSB first.
- Runs a comma-only training sequence after enable so the far-end deserializer can align and lock.
- Fills any FIFO underrun with commas, so the line never carries unframed bits.

---
 rtl/serializer_10b.sv | 143 ++++++++++++++
 tb/tb_serializer_10b.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_10b.sv
// ---------------------------------------------------------------------------
// serializer_10b
// Transmit side of the 10-bit link. Pops pre-encoded 10-bit words from a TX
// FIFO and shifts them onto the line LSB first, one bit per clk. After enable
// it sends a run of alternating commas so the far end can align and lock.
// Whenever the FIFO has nothing ready, it sends commas instead of data.
//
// Ports
//   clk         link bit clock
//   rst_n       asynchronous active-low reset
//   tx_enable   level: start / keep transmitting
//   fifo_empty  TX FIFO empty flag
//   fifo_data   TX FIFO read data, valid the cycle after rd_en
//   rd_en       FIFO pop strobe (bit_cnt==8 cycle only)
//   serial_out  line bit, LSB of the shift register
//   word_start  high while bit 0 of each word is on the line
//   training    high while sending the training commas
//   link_up     high while in the data phase
// ---------------------------------------------------------------------------
module serializer_10b #(
    parameter int          TRAIN_COMMAS = 8,
    parameter logic [9:0]  COMMA_P      = 10'b1100000101,
    parameter logic [9:0]  COMMA_N      = 10'b0011111010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [9:0] fifo_data,
    output logic       rd_en,
    output logic       serial_out,
    output logic       word_start,
    output logic       training,
    output logic       link_up
);

    localparam int TCW = $clog2(TRAIN_COMMAS + 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TRAIN = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       bit_cnt;
    logic [TCW-1:0]   train_cnt;   // commas already completed in TRAIN
    logic [9:0]       shift_reg;
    logic             sel_n;       // 1: next comma is COMMA_N
    logic             fetched;     // a FIFO word was popped for the next slot
    logic             last_train;
    logic             keep_going;
    logic [9:0]       comma_next;

    assign last_train = (state == TRAIN) && (train_cnt == TCW'(TRAIN_COMMAS - 1));
    assign comma_next = sel_n ? COMMA_N : COMMA_P;
    // A popped word must always be sent, so it keeps the link alive even if
    // tx_enable dropped after the pop.
    assign keep_going = fetched || tx_enable;

    // The pop has to see fifo_empty in the very bit_cnt==8 cycle, so rd_en is
    // decoded from registered state plus the live flags. Gating with
    // tx_enable means the final word of a session never strands a FIFO word.
    assign rd_en = ((state == DATA) || last_train) && (bit_cnt == 4'd8) &&
                   !fifo_empty && tx_enable;

    assign serial_out = shift_reg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OFF;
            bit_cnt    <= 4'd0;
            train_cnt  <= '0;
            shift_reg  <= 10'd0;
            sel_n      <= 1'b0;
            fetched    <= 1'b0;
            word_start <= 1'b0;
            training   <= 1'b0;
            link_up    <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    bit_cnt   <= 4'd0;
                    train_cnt <= '0;
                    fetched   <= 1'b0;
                    link_up   <= 1'b0;
                    if (tx_enable) begin
                        state      <= TRAIN;
                        shift_reg  <= COMMA_P;
                        sel_n      <= 1'b1;
                        word_start <= 1'b1;
                        training   <= 1'b1;
                    end else begin
                        shift_reg  <= 10'd0;
                        sel_n      <= 1'b0;
                        word_start <= 1'b0;
                        training   <= 1'b0;
                    end
                end

                default: begin
                    if (bit_cnt != 4'd9) begin
                        shift_reg  <= shift_reg >> 1;
                        bit_cnt    <= bit_cnt + 4'd1;
                        word_start <= 1'b0;
                        if (bit_cnt == 4'd8)
                            fetched <= rd_en;
                    end else begin
                        // word boundary
                        bit_cnt <= 4'd0;
                        fetched <= 1'b0;
                        if (!keep_going) begin
                            state      <= OFF;
                            shift_reg  <= 10'd0;
                            word_start <= 1'b0;
                            training   <= 1'b0;
                            link_up    <= 1'b0;
                            train_cnt  <= '0;
                            sel_n      <= 1'b0;
                        end else begin
                            word_start <= 1'b1;
                            // data words leave the comma alternation untouched
                            if (fetched) begin
                                shift_reg <= fifo_data;
                            end else begin
                                shift_reg <= comma_next;
                                sel_n     <= ~sel_n;
                            end
                            if ((state == TRAIN) && !last_train) begin
                                train_cnt <= train_cnt + 1'b1;
                            end else begin
                                state    <= DATA;
                                training <= 1'b0;
                                link_up  <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_10b.sv
// ---------------------------------------------------------------------------
// tb_serializer_10b
// Randomized scoreboard bench for serializer_10b. The stimulus process keeps a
// word-slot model of the line (fixed 10-clk slots, training comma count,
// alternating commas, pop decided by the flags at bit 8 of each slot) and
// pushes the expected word per slot. A monitor rebuilds each word from
// serial_out starting at word_start and checks it against the queue. A FIFO
// responder serves rd_en from the same data table with 1-cycle latency.
// ---------------------------------------------------------------------------
module tb_serializer_10b;

    localparam int         TRAIN_COMMAS = 8;
    localparam logic [9:0] COMMA_P      = 10'b1100000101;
    localparam logic [9:0] COMMA_N      = 10'b0011111010;

    logic       clk;
    logic       rst_n;
    logic       tx_enable;
    logic       fifo_empty;
    logic [9:0] fifo_data;
    logic       rd_en;
    logic       serial_out;
    logic       word_start;
    logic       training;
    logic       link_up;

    serializer_10b #(
        .TRAIN_COMMAS (TRAIN_COMMAS),
        .COMMA_P      (COMMA_P),
        .COMMA_N      (COMMA_N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .rd_en      (rd_en),
        .serial_out (serial_out),
        .word_start (word_start),
        .training   (training),
        .link_up    (link_up)
    );

    typedef struct {
        logic [9:0] w;
        bit         tr;
        bit         lu;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] data_mem [0:1023];
    int         checks   = 0;
    int         failures = 0;
    int         ridx     = 0;   // words handed out by the FIFO responder
    int         midx     = 0;   // words consumed by the model

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // FIFO responder: data appears the cycle after the pop, junk otherwise
    initial begin
        bit pend;
        fifo_data = 10'd0;
        forever begin
            @(negedge clk);
            #1;
            pend = rd_en;
            if (rd_en) chk("rd_en_while_empty", fifo_empty, 0);
            @(posedge clk);
            #1;
            if (pend) begin
                fifo_data = data_mem[ridx];
                ridx++;
            end else begin
                fifo_data = 10'($urandom);
            end
        end
    end

    // Monitor: rebuild a word from 10 line bits, abort on reset
    initial begin
        logic [9:0] w;
        bit         tr, lu, ok;
        exp_t       e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && word_start) begin
                w     = 10'd0;
                w[0]  = serial_out;
                tr    = training;
                lu    = link_up;
                ok    = 1'b1;
                for (int i = 1; i < 10; i++) begin
                    @(posedge clk);
                    #2;
                    if (!rst_n) begin
                        ok = 1'b0;
                        break;
                    end
                    w[i] = serial_out;
                    chk("word_start_mid_word", word_start, 0);
                end
                if (ok) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got 0x%0h, required no word", w);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", w, e.w);
                        chk("training", tr, e.tr);
                        chk("link_up", lu, e.lu);
                    end
                end
            end
        end
    end

    // Several cycles in OFF: everything quiet, scoreboard drained
    task automatic check_off(input int n);
        chk("queue_drained", exp_q.size(), 0);
        chk("pop_count", ridx, midx);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fifo_empty = ($urandom_range(1) == 0);
            #1;
            chk("off_outputs", {serial_out, word_start, training, link_up, rd_en}, 0);
        end
    endtask

    // Called at a negedge with the DUT in OFF. Runs one enable session.
    task automatic run_session(input int drop_slot, input int drop_bit,
                               input int empty_pct, input int rst_slot);
        int   s, b, c;
        bit   pop;
        exp_t e;
        c   = 0;
        pop = 1'b0;
        tx_enable = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5000; k++) begin
            s = k / 10;
            b = k % 10;
            @(negedge clk);
            if (b == 0) begin
                if (pop) begin
                    e.w = data_mem[midx];
                    midx++;
                    e.tr = 1'b0;
                    e.lu = 1'b1;
                end else begin
                    e.w  = (c % 2 == 0) ? COMMA_P : COMMA_N;
                    c++;
                    e.tr = (s < TRAIN_COMMAS);
                    e.lu = !e.tr;
                end
                exp_q.push_back(e);
            end
            if (s == rst_slot && b == 5) begin
                rst_n = 1'b0;
                exp_q.delete();
                #1;
                chk("reset_mid_word", {serial_out, word_start, training, link_up, rd_en}, 0);
                tx_enable = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (s == drop_slot && b == drop_bit) tx_enable = 1'b0;
            fifo_empty = ($urandom_range(99) < empty_pct);
            if (b == 8) pop = tx_enable && !fifo_empty && (s >= TRAIN_COMMAS - 1);
            if (b == 9 && !tx_enable) return;
        end
        checks++;
        failures++;
        $display("FAIL session_bound: got no end, required session end");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) data_mem[i] = 10'($urandom);
        data_mem[0] = 10'h2AA;
        data_mem[1] = 10'h155;

        rst_n      = 1'b0;
        tx_enable  = 1'b1;
        fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {serial_out, word_start, training, link_up, rd_en}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // full FIFO, leave at bit 3 of a data word
        run_session(12, 3, 0, -1);
        check_off(3);
        // random underruns
        run_session(30, $urandom_range(8), 50, -1);
        check_off(3);
        // drop during training
        run_session(3, 6, 0, -1);
        check_off(3);
        // permanent underrun: pure idle fill, drop exactly at bit 8
        run_session(14, 8, 100, -1);
        check_off(3);
        // reset in the middle of a data word
        run_session(1000, 0, 30, 15);
        check_off(4);
        // restart after reset
        run_session(20, 5, 20, -1);
        check_off(3);
        for (int r = 0; r < 4; r++) begin
            run_session($urandom_range(25, 5), $urandom_range(8),
                        $urandom_range(80), -1);
            check_off(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
